// File: rtl/scemi_in_msg_buffer_if.sv
// Valid/ready message channel used on both sides of scemi_in_msg_buffer.
// master drives valid/data, slave drives ready.
interface scemi_in_msg_buffer_if #(
   parameter int PORT_WIDTH = 32
) ();
   logic                  valid;
   logic                  ready;
   logic [PORT_WIDTH-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/scemi_in_msg_buffer.sv
// Receive-side buffer behind a SceMiMessageInPort: FWFT FIFO, message counter, done after MSG_LIMIT pops.
// Optional consumer-stall watchdog enabled by SCEMI_IN_MSG_BUFFER_STALL_CHECK_EN.
module scemi_in_msg_buffer #(
   parameter int PORT_WIDTH  = 32,
   parameter int DEPTH       = 4,
   parameter int CNT_WIDTH   = 16,
   parameter int MSG_LIMIT   = 10
`ifdef SCEMI_IN_MSG_BUFFER_STALL_CHECK_EN
   , parameter int STALL_LIMIT = 1000
`endif
) (
   input  logic                       clk,
   input  logic                       rst_n,
   scemi_in_msg_buffer_if.slave       msg,
   scemi_in_msg_buffer_if.master      out,
   output logic [$clog2(DEPTH):0]     level,
   output logic [CNT_WIDTH-1:0]       rx_count,
   output logic                       done
`ifdef SCEMI_IN_MSG_BUFFER_STALL_CHECK_EN
   , output logic                     stall_err
`endif
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam int CW = (MSG_LIMIT < 2) ? 1 : $clog2(MSG_LIMIT + 1);
   localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
   localparam logic [CW-1:0] POP_LIM   = CW'(MSG_LIMIT);
   localparam bit            LIMIT_EN  = (MSG_LIMIT != 0);

   logic [PORT_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]         level_q, level_d;
   logic [CNT_WIDTH-1:0]  rx_count_q, rx_count_d;
   logic [CW-1:0]         pop_cnt_q, pop_cnt_d;
   logic                  done_q, done_d;
   logic                  run_q, run_d;
   logic                  msg_ready_w, out_valid_w, push, pop;

   // run_q keeps msg_ready low throughout reset and sets on the first edge after release.
   assign msg_ready_w = run_q && (level_q != FULL_LVL) && !done_q;
   assign out_valid_w = (level_q != '0);
   assign push        = msg.valid && msg_ready_w;
   assign pop         = out_valid_w && out.ready;

   assign msg.ready = msg_ready_w;
   assign out.valid = out_valid_w;
   assign out.data  = mem_q[rd_ptr_q];
   assign level     = level_q;
   assign rx_count  = rx_count_q;
   assign done      = done_q;

   always_comb begin
      run_d      = 1'b1;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      rx_count_d = rx_count_q;
      pop_cnt_d  = pop_cnt_q;
      done_d     = done_q;
      if (push) begin
         wr_ptr_d   = wr_ptr_q + PW'(1);
         rx_count_d = rx_count_q + CNT_WIDTH'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      // Pop counter saturates at the limit; done is sticky until reset.
      if (LIMIT_EN && pop && (pop_cnt_q != POP_LIM)) begin
         pop_cnt_d = pop_cnt_q + CW'(1);
         if (pop_cnt_d == POP_LIM) done_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         rx_count_q <= '0;
         pop_cnt_q  <= '0;
         done_q     <= 1'b0;
      end else begin
         run_q      <= run_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         rx_count_q <= rx_count_d;
         pop_cnt_q  <= pop_cnt_d;
         done_q     <= done_d;
      end
   end

   // Storage is not reset; only pointers and level define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= msg.data;
   end

`ifdef SCEMI_IN_MSG_BUFFER_STALL_CHECK_EN
   localparam logic [31:0] STALL_LIM = 32'(STALL_LIMIT);
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic        stall_err_q, stall_err_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!out_valid_w || pop)           stall_cnt_d = '0;
      else if (stall_cnt_q != STALL_LIM) stall_cnt_d = stall_cnt_q + 32'd1;
      stall_err_d = stall_err_q || (stall_cnt_d == STALL_LIM);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         stall_err_q <= 1'b0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         stall_err_q <= stall_err_d;
         if (stall_err_d && !stall_err_q) $display("scemi_in_msg_buffer: consumer stall");
      end
   end

   assign stall_err = stall_err_q;
`endif
endmodule
